dbg_bus_bridge: RTL and testbench

Parametrised successor to the team's byte-stream debug command decoder. It parses commands from an 8-bit RX FIFO and issues single or burst APB-style accesses. Address and data widths are configurable. Each command carries a fixed or incrementing address mode. Every bus access waits for completion, with slave-error and timeout detection, and each command ends with one status byte on the 8-bit TX FIFO.

---
 rtl/dbg_pkg.sv | 36 +++
 rtl/dbg_shift_reg.sv | 46 ++++
 rtl/dbg_bus_bridge.sv | 183 ++++++++++++++++++
 tb/tb_dbg_bus_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the byte-stream debug bus bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WACC,
        S_RACC,
        S_RSEND,
        S_STATUS
    } state_t;

    // Command header layout
    localparam int HDR_WRITE   = 7;
    localparam int HDR_INCR    = 6;
    localparam int HDR_LEN_MSB = 5;
    localparam int HDR_LEN_LSB = 0;

    // Status byte layout
    localparam int ST_MARK = 7;
    localparam int ST_ERR  = 6;
    localparam int ST_TOUT = 5;

    function automatic logic [7:0] status_byte(input logic err, input logic tout);
        logic [7:0] s;
        s          = 8'h00;
        s[ST_MARK] = 1'b1;
        s[ST_ERR]  = err;
        s[ST_TOUT] = tout;
        return s;
    endfunction

endpackage

// File: rtl/dbg_shift_reg.sv
// Byte-serial shift register with byte counter; MSB-first in or out, parallel load.
// Latency: shifted/loaded value visible the cycle after shift/load.
// Backpressure: none internal; caller gates shift with its own handshake.
//
// Ports: clr zeroes data and counter; load writes load_dat and restarts the
// counter; shift moves data left one byte, inserting shift_in_dat at the LSB.
// last is high while the counter sits on the final byte of the word, so a
// shift with last=1 completes the word and returns the counter to zero.
module dbg_shift_reg #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [8*NBYTES-1:0]   load_dat,
    input  logic                  shift,
    input  logic [7:0]            shift_in_dat,
    output logic [8*NBYTES-1:0]   dat,
    output logic                  last
);

    localparam int W = 8 * NBYTES;

    logic [2:0] cnt;

    assign last = (cnt == 3'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat <= '0;
            cnt <= '0;
        end else if (clr) begin
            dat <= '0;
            cnt <= '0;
        end else if (load) begin
            dat <= load_dat;
            cnt <= '0;
        end else if (shift) begin
            // Truncating cast drops the outgoing top byte; works for NBYTES=1 too.
            dat <= W'({dat, shift_in_dat});
            cnt <= last ? 3'd0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/dbg_bus_bridge.sv
// Parses header/address/data bytes from an RX FIFO and runs single or burst bus accesses.
// Latency: last address/data byte popped -> o_penable high the next cycle.
// Backpressure: RX empty stalls parsing, TX full stalls read data and status output.
//
// Ports: i_fifo_* / o_fifo_read form the RX byte side (pop consumes the byte in
// the same cycle); i_fifo_full / o_fifo_write / o_fifo_wdata form the TX side;
// o_penable..o_pwdata and i_pready/i_prdata/i_pslverr form the bus master side.
module dbg_bus_bridge
    import dbg_pkg::*;
#(
    parameter int ADDR_BYTES  = 4,
    parameter int DATA_BYTES  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_read,
    input  logic [7:0]              i_fifo_rdata,
    input  logic                    i_fifo_full,
    output logic                    o_fifo_write,
    output logic [7:0]              o_fifo_wdata,
    output logic                    o_penable,
    output logic                    o_pwrite,
    output logic [8*ADDR_BYTES-1:0] o_paddr,
    output logic [8*DATA_BYTES-1:0] o_pwdata,
    input  logic                    i_pready,
    input  logic [8*DATA_BYTES-1:0] i_prdata,
    input  logic                    i_pslverr
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Counter value in the last cycle the access may still wait.
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t          state;
    logic            wr_f, incr_f, err_f, tout_f;
    logic [5:0]      beats_left;
    logic [TW-1:0]   to_cnt;

    logic            rx_pop, tx_push, acc_tout, acc_end, beat_end, hdr_pop;
    logic            addr_last, wd_last, rd_last;
    logic [AW-1:0]   addr_dat;
    logic [DW-1:0]   wd_dat, rd_dat;

    // Pop/push are combinational: the FIFOs hand over a byte in the cycle the
    // strobe is high, so the strobe must see the current empty/full flags.
    assign rx_pop   = !i_fifo_empty && (state inside {S_IDLE, S_ADDR, S_WDATA});
    assign tx_push  = !i_fifo_full  && (state inside {S_RSEND, S_STATUS});
    assign hdr_pop  = (state == S_IDLE) && rx_pop;

    // Ready in the expiry cycle wins over the timeout.
    assign acc_tout = (TIMEOUT_CYC != 0) && !i_pready && (to_cnt == TO_LAST);
    assign acc_end  = (state inside {S_WACC, S_RACC}) && (i_pready || acc_tout);
    assign beat_end = ((state == S_WACC) && acc_end) ||
                      ((state == S_RSEND) && tx_push && rd_last);

    assign o_fifo_read  = rx_pop;
    assign o_fifo_write = tx_push;
    assign o_fifo_wdata = !tx_push           ? 8'h00 :
                          (state == S_RSEND) ? rd_dat[DW-1 -: 8] :
                                               status_byte(err_f, tout_f);
    assign o_paddr  = addr_dat;
    assign o_pwdata = wd_dat;

    dbg_shift_reg #(.NBYTES(ADDR_BYTES)) u_addr (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .clr          (hdr_pop),
        .load         (beat_end && (beats_left != 6'd0) && incr_f),
        .load_dat     (addr_dat + AW'(DATA_BYTES)),
        .shift        ((state == S_ADDR) && rx_pop),
        .shift_in_dat (i_fifo_rdata),
        .dat          (addr_dat),
        .last         (addr_last)
    );

    dbg_shift_reg #(.NBYTES(DATA_BYTES)) u_wdata (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .clr          (hdr_pop),
        .load         (1'b0),
        .load_dat     ('0),
        .shift        ((state == S_WDATA) && rx_pop),
        .shift_in_dat (i_fifo_rdata),
        .dat          (wd_dat),
        .last         (wd_last)
    );

    // An abandoned read returns zeros rather than whatever sits on i_prdata.
    dbg_shift_reg #(.NBYTES(DATA_BYTES)) u_rdata (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .clr          (hdr_pop),
        .load         ((state == S_RACC) && acc_end),
        .load_dat     (i_pready ? i_prdata : '0),
        .shift        ((state == S_RSEND) && tx_push),
        .shift_in_dat (8'h00),
        .dat          (rd_dat),
        .last         (rd_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wr_f       <= 1'b0;
            incr_f     <= 1'b0;
            err_f      <= 1'b0;
            tout_f     <= 1'b0;
            beats_left <= '0;
            to_cnt     <= '0;
            o_penable  <= 1'b0;
            o_pwrite   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_pop) begin
                        wr_f       <= i_fifo_rdata[HDR_WRITE];
                        incr_f     <= i_fifo_rdata[HDR_INCR];
                        beats_left <= i_fifo_rdata[HDR_LEN_MSB:HDR_LEN_LSB];
                        err_f      <= 1'b0;
                        tout_f     <= 1'b0;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_pop && addr_last) begin
                        if (wr_f) begin
                            state <= S_WDATA;
                        end else begin
                            state     <= S_RACC;
                            o_penable <= 1'b1;
                            to_cnt    <= '0;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_pop && wd_last) begin
                        state     <= S_WACC;
                        o_penable <= 1'b1;
                        o_pwrite  <= 1'b1;
                        to_cnt    <= '0;
                    end
                end
                S_WACC, S_RACC: begin
                    if (acc_end) begin
                        o_penable <= 1'b0;
                        o_pwrite  <= 1'b0;
                        if (i_pready && i_pslverr) err_f  <= 1'b1;
                        if (!i_pready)             tout_f <= 1'b1;
                        if (state == S_RACC)       state  <= S_RSEND;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RSEND: ;
                S_STATUS: begin
                    if (tx_push) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Shared beat sequencing for write completion and last read byte.
            if (beat_end) begin
                if (beats_left != 6'd0) begin
                    beats_left <= beats_left - 6'd1;
                    if (wr_f) begin
                        state <= S_WDATA;
                    end else begin
                        state     <= S_RACC;
                        o_penable <= 1'b1;
                        to_cnt    <= '0;
                    end
                end else begin
                    state <= S_STATUS;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbg_bus_bridge.sv
`timescale 1ns/1ps
module tb_dbg_bus_bridge;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: 4/4 bytes, timeout 4 ----------------
    logic        a_empty, a_read, a_full, a_write, a_pen, a_pwrite, a_pready, a_pslverr;
    logic [7:0]  a_rdata, a_wdata;
    logic [31:0] a_paddr, a_pwdata, a_prdata;

    dbg_bus_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT_CYC(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_empty(a_empty), .o_fifo_read(a_read), .i_fifo_rdata(a_rdata),
        .i_fifo_full(a_full), .o_fifo_write(a_write), .o_fifo_wdata(a_wdata),
        .o_penable(a_pen), .o_pwrite(a_pwrite), .o_paddr(a_paddr), .o_pwdata(a_pwdata),
        .i_pready(a_pready), .i_prdata(a_prdata), .i_pslverr(a_pslverr)
    );

    logic [7:0]  rxa_mem [0:255];
    int          rxa_wr = 0, rxa_rd = 0;
    logic [7:0]  txa_mem [0:255];
    int          txa_n = 0;
    logic        rx_gap_en = 1'b0, tx_tog_en = 1'b0;
    int          a_dly = 0, a_wait = 0, a_viol = 0;
    logic [31:0] rd_tab [0:31];
    logic        err_tab [0:31];
    int          rise_n = 0, done_n = 0, run = 0, last_pop = 0;
    logic        pen_d = 1'b0, pwr_d = 1'b0;
    logic [31:0] pa_d = '0, pw_d = '0;
    logic [31:0] acc_addr [0:31];
    logic [31:0] acc_wdata [0:31];
    logic        acc_wr [0:31];
    int          en_len [0:31];
    int          lat [0:31];

    assign a_empty   = (rxa_rd == rxa_wr) || (rx_gap_en && cyc[1]);
    assign a_rdata   = rxa_mem[rxa_rd[7:0]];
    assign a_full    = tx_tog_en && cyc[0];
    assign a_pready  = a_pen && (a_wait == a_dly);
    assign a_prdata  = a_pready ? rd_tab[done_n[4:0]] : 32'hFFFF_FFFF;
    assign a_pslverr = a_pready && err_tab[done_n[4:0]];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pen_d <= a_pen;
        pa_d  <= a_paddr;
        pw_d  <= a_pwdata;
        pwr_d <= a_pwrite;
        if (a_read) begin
            rxa_rd   <= rxa_rd + 1;
            last_pop <= cyc;
        end
        if ((a_read && a_empty) || (a_write && a_full)) a_viol <= a_viol + 1;
        if (a_pen && pen_d && (a_paddr != pa_d || a_pwdata != pw_d || a_pwrite != pwr_d))
            a_viol <= a_viol + 1;
        if (a_write) begin
            txa_mem[txa_n[7:0]] <= a_wdata;
            txa_n <= txa_n + 1;
        end
        if (a_pen) begin
            a_wait <= a_pready ? 0 : a_wait + 1;
            run    <= run + 1;
        end else begin
            a_wait <= 0;
        end
        if (a_pen && !pen_d) begin
            acc_addr[rise_n[4:0]]  <= a_paddr;
            acc_wdata[rise_n[4:0]] <= a_pwdata;
            acc_wr[rise_n[4:0]]    <= a_pwrite;
            lat[rise_n[4:0]]       <= cyc - last_pop;
            rise_n <= rise_n + 1;
        end
        if (!a_pen && pen_d) begin
            en_len[done_n[4:0]] <= run;
            run    <= 0;
            done_n <= done_n + 1;
        end
    end

    // ---------------- instance B: 2/2 bytes, always-ready slave ----------------
    logic        b_empty, b_read, b_full, b_write, b_pen, b_pwrite, b_pready, b_pslverr;
    logic [7:0]  b_rdata, b_wdata;
    logic [15:0] b_paddr, b_pwdata, b_prdata;

    dbg_bus_bridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYC(255)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_empty(b_empty), .o_fifo_read(b_read), .i_fifo_rdata(b_rdata),
        .i_fifo_full(b_full), .o_fifo_write(b_write), .o_fifo_wdata(b_wdata),
        .o_penable(b_pen), .o_pwrite(b_pwrite), .o_paddr(b_paddr), .o_pwdata(b_pwdata),
        .i_pready(b_pready), .i_prdata(b_prdata), .i_pslverr(b_pslverr)
    );

    logic [7:0]  rxb_mem [0:15];
    int          rxb_wr = 0, rxb_rd = 0;
    logic [7:0]  txb_mem [0:15];
    int          txb_n = 0, rise_b = 0;
    logic        penb_d = 1'b0;
    logic [15:0] accb_addr [0:7];

    assign b_empty   = (rxb_rd == rxb_wr);
    assign b_rdata   = rxb_mem[rxb_rd[3:0]];
    assign b_full    = 1'b0;
    assign b_pready  = b_pen;
    assign b_prdata  = b_paddr ^ 16'hA5A5;
    assign b_pslverr = 1'b0;

    always @(posedge clk) begin
        penb_d <= b_pen;
        if (b_read) rxb_rd <= rxb_rd + 1;
        if (b_write) begin
            txb_mem[txb_n[3:0]] <= b_wdata;
            txb_n <= txb_n + 1;
        end
        if (b_pen && !penb_d) begin
            accb_addr[rise_b[2:0]] <= b_paddr;
            rise_b <= rise_b + 1;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] seq [$];
    logic [7:0] exp_q [$];
    int base_tx, base_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq_a();
        foreach (seq[i]) begin
            rxa_mem[rxa_wr[7:0]] = seq[i];
            rxa_wr = rxa_wr + 1;
        end
    endtask

    // Waits (bounded) for the expected TX bytes, then compares them in order.
    task automatic check_tx_a(input string tag, input int base);
        int n;
        n = base + exp_q.size();
        for (int k = 0; k < 3000 && txa_n < n; k++) @(negedge clk);
        chk({tag, "_arrive"}, 32'(txa_n >= n), 32'd1);
        repeat (6) @(negedge clk);
        chk({tag, "_count"}, txa_n, n);
        foreach (exp_q[i]) chk({tag, "_byte"}, {24'h0, txa_mem[base + i]}, {24'h0, exp_q[i]});
    endtask

    task automatic start_test();
        @(negedge clk);
        base_tx  = txa_n;
        base_acc = rise_n;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            rd_tab[i]  = 32'h0;
            err_tab[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {22'h0, a_read, a_write, a_wdata}, 32'h0);
        chk("rst_bus", {30'h0, a_pen, a_pwrite}, 32'h0);
        chk("rst_paddr", a_paddr, 32'h0);
        chk("rst_pwdata", a_pwdata, 32'h0);
        rst_n = 1'b1;

        // Single write
        start_test();
        a_dly = 2;
        seq = '{8'h80, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_seq_a();
        exp_q = '{8'h80};
        check_tx_a("t1_tx", base_tx);
        chk("t1_nacc", rise_n - base_acc, 1);
        chk("t1_paddr", acc_addr[base_acc[4:0]], 32'h0000_1000);
        chk("t1_pwrite", {31'h0, acc_wr[base_acc[4:0]]}, 32'h1);
        chk("t1_pwdata", acc_wdata[base_acc[4:0]], 32'hDEAD_BEEF);
        chk("t1_enlen", en_len[base_acc[4:0]], 3);
        chk("t1_latency", lat[base_acc[4:0]], 1);

        // Incrementing read burst, 3 beats
        start_test();
        a_dly = 1;
        rd_tab[base_acc[4:0]]       = 32'h1111_1111;
        rd_tab[base_acc[4:0] + 5'd1] = 32'h2222_2222;
        rd_tab[base_acc[4:0] + 5'd2] = 32'h3333_3333;
        seq = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h20};
        push_seq_a();
        exp_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                  8'h33, 8'h33, 8'h33, 8'h33, 8'h80};
        check_tx_a("t2_tx", base_tx);
        chk("t2_nacc", rise_n - base_acc, 3);
        chk("t2_paddr0", acc_addr[base_acc[4:0]], 32'h20);
        chk("t2_paddr1", acc_addr[base_acc[4:0] + 5'd1], 32'h24);
        chk("t2_paddr2", acc_addr[base_acc[4:0] + 5'd2], 32'h28);
        chk("t2_pwrite", {31'h0, acc_wr[base_acc[4:0] + 5'd2]}, 32'h0);

        // Fixed-address write burst, 2 beats
        start_test();
        a_dly = 0;
        seq = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h40,
                8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        push_seq_a();
        exp_q = '{8'h80};
        check_tx_a("t3_tx", base_tx);
        chk("t3_nacc", rise_n - base_acc, 2);
        chk("t3_paddr0", acc_addr[base_acc[4:0]], 32'h40);
        chk("t3_paddr1", acc_addr[base_acc[4:0] + 5'd1], 32'h40);
        chk("t3_pwdata0", acc_wdata[base_acc[4:0]], 32'h0102_0304);
        chk("t3_pwdata1", acc_wdata[base_acc[4:0] + 5'd1], 32'hA55A_C33C);
        chk("t3_latency1", lat[base_acc[4:0] + 5'd1], 1);

        // Timeout: slave never ready
        start_test();
        a_dly = 99;
        seq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        push_seq_a();
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0};
        check_tx_a("t4a_tx", base_tx);
        chk("t4a_enlen", en_len[base_acc[4:0]], 4);

        // Ready in the expiry cycle completes normally
        start_test();
        a_dly = 3;
        rd_tab[base_acc[4:0]] = 32'h5A5A_1234;
        push_seq_a();
        exp_q = '{8'h5A, 8'h5A, 8'h12, 8'h34, 8'h80};
        check_tx_a("t4b_tx", base_tx);
        chk("t4b_enlen", en_len[base_acc[4:0]], 4);

        // Slave error on beat 1 with RX gaps and TX back-pressure
        start_test();
        a_dly = 1;
        rd_tab[base_acc[4:0]]        = 32'hCAFE_F00D;
        rd_tab[base_acc[4:0] + 5'd1] = 32'h0BAD_BEEF;
        err_tab[base_acc[4:0]]       = 1'b1;
        rx_gap_en = 1'b1;
        tx_tog_en = 1'b1;
        seq = '{8'h41, 8'h00, 8'h00, 8'h02, 8'h00};
        push_seq_a();
        exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B, 8'hAD, 8'hBE, 8'hEF, 8'hC0};
        check_tx_a("t5_tx", base_tx);
        chk("t5_paddr0", acc_addr[base_acc[4:0]], 32'h200);
        chk("t5_paddr1", acc_addr[base_acc[4:0] + 5'd1], 32'h204);
        rx_gap_en = 1'b0;
        tx_tog_en = 1'b0;
        chk("handshake_stability", a_viol, 0);

        // Reset in the middle of write data
        start_test();
        a_dly = 0;
        seq = '{8'h80, 8'h00, 8'h00, 8'h30, 8'h00, 8'h11, 8'h22};
        push_seq_a();
        for (int k = 0; k < 200 && rxa_rd != rxa_wr; k++) @(negedge clk);
        chk("t6_rx_drained", 32'(rxa_rd == rxa_wr), 32'd1);
        repeat (2) @(negedge clk);
        chk("t6_partial_wdata", a_pwdata, 32'h0000_1122);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_paddr", a_paddr, 32'h0);
        chk("t6_rst_pwdata", a_pwdata, 32'h0);
        chk("t6_rst_ctrl", {21'h0, a_pen, a_pwrite, a_write, a_wdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_status", txa_n, base_tx);
        chk("t6_no_access", rise_n, base_acc);
        seq = '{8'h80, 8'h00, 8'h00, 8'h30, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
        push_seq_a();
        exp_q = '{8'h80};
        check_tx_a("t6_tx", base_tx);
        chk("t6_paddr", acc_addr[base_acc[4:0]], 32'h0000_3000);
        chk("t6_pwdata", acc_wdata[base_acc[4:0]], 32'h5566_7788);

        // 2-byte address/data: incrementing read wraps the address
        @(negedge clk);
        rxb_mem[0] = 8'h41;
        rxb_mem[1] = 8'hFF;
        rxb_mem[2] = 8'hFE;
        rxb_wr = 3;
        for (int k = 0; k < 500 && txb_n < 5; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("t7_count", txb_n, 5);
        chk("t7_paddr0", {16'h0, accb_addr[0]}, 32'hFFFE);
        chk("t7_paddr1", {16'h0, accb_addr[1]}, 32'h0000);
        chk("t7_byte0", {24'h0, txb_mem[0]}, 32'h5A);
        chk("t7_byte1", {24'h0, txb_mem[1]}, 32'h5B);
        chk("t7_byte2", {24'h0, txb_mem[2]}, 32'hA5);
        chk("t7_byte3", {24'h0, txb_mem[3]}, 32'hA5);
        chk("t7_status", {24'h0, txb_mem[4]}, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
